// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory access stage with fixed wait states, byte/half/word lanes and load extension.
// Stalls EX/MEM while busy and pulses Done (plus AddrErr on misalignment) when the access finishes.
module mem_access_stage #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        Valid_in,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        Byte,
    input  logic        Half,
    input  logic        UnsignedExt_Mem,
    output logic [31:0] RData,
    output logic        Done,
    output logic        AddrErr,
    output logic        Stall
);
    localparam int AW = ADDR_WIDTH + 2;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic we_q, we_d, byte_q, byte_d, half_q, half_d, uns_q, uns_d, err_q, err_d;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic req, misal, fire;
    logic [31:0] word, ext, wlane;
    logic [7:0] bsel;
    logic [15:0] hsel;
    logic [3:0] mask;

    assign req   = Valid_in & (MemWrite | MemRead);
    assign misal = ~Byte & (Half ? Addr[0] : |Addr[1:0]);
    assign fire  = state_q == BUSY && cnt_q == 4'd0;
    assign word  = mem[addr_q[AW-1:2]];
    assign bsel  = word[{addr_q[1:0], 3'b000} +: 8];
    assign hsel  = addr_q[1] ? word[31:16] : word[15:0];
    assign ext   = byte_q ? {{24{~uns_q & bsel[7]}}, bsel}
                 : half_q ? {{16{~uns_q & hsel[15]}}, hsel} : word;
    assign mask  = byte_q ? 4'b0001 << addr_q[1:0]
                 : half_q ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlane = byte_q ? {4{wdata_q[7:0]}} : half_q ? {2{wdata_q[15:0]}} : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        byte_d  = byte_q;
        half_d  = half_q;
        uns_d   = uns_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = Addr[AW-1:0];
                wdata_d = WData;
                we_d    = MemWrite;
                byte_d  = Byte;
                half_d  = Half & ~Byte;
                uns_d   = UnsignedExt_Mem;
                err_d   = misal;
                cnt_d   = 4'(WAIT_CYCLES - 1);
                state_d = misal ? DONE : BUSY;
                rdata_d = misal ? '0 : rdata_q;
            end
            BUSY: if (cnt_q == 4'd0) begin
                state_d = DONE;
                rdata_d = we_q ? '0 : ext;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            half_q  <= half_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

    // RAM is never cleared; writes land only on the BUSY-to-DONE edge so CLR aborts cleanly
    always_ff @(posedge clk) begin
        if (!CLR && fire && we_q)
            for (int i = 0; i < 4; i++)
                if (mask[i]) mem[addr_q[AW-1:2]][i*8 +: 8] <= wlane[i*8 +: 8];
    end

    assign RData   = rdata_q;
    assign Done    = state_q == DONE;
    assign AddrErr = Done & err_q;
    assign Stall   = ~CLR & ((state_q == IDLE & req) | state_q == BUSY);
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage of the pipelined CPU, sitting directly downstream of the EX/MEM pipeline registers and signal latches. It performs word, halfword and byte loads and stores against an internal data RAM with a fixed number of wait states, sign- or zero-extends loaded data, and raises a stall so the EX/MEM latches hold their contents until the access completes. Its load data and completion flag feed the MEM/WB register.

## Interface
- ADDR_WIDTH, default 10: number of word-index bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, default 2: number of BUSY cycles per access; legal range is 1 to 15.

- clk  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset, synchronous, active-high.
- Valid_in  input  1  the EX/MEM valid bit.
- Addr  input  32  byte address, the ALU result from EX/MEM R1.
- WData  input  32  store data, the rt value from EX/MEM RD2.
- MemWrite  input  1  store request.
- MemRead  input  1  load request, the EX/MEM MemtoReg bit.
- Byte  input  1  byte access.
- Half  input  1  halfword access.
- UnsignedExt_Mem  input  1  zero-extend on load; sign-extend when low.
- RData  output  32  extended load data; held until the next access completes.
- Done  output  1  one-cycle pulse when an access finishes.
- AddrErr  output  1  one-cycle pulse with Done for a misaligned access.
- Stall  output  1  combinational; drives EN low on the EX/MEM latches and upstream stages.

## Operation
- A request is present when Valid_in=1 and (MemWrite | MemRead) = 1.
- Access size is selected by priority:
  - Byte=1 gives a byte access.
  - Otherwise Half=1 gives a halfword access.
  - Otherwise the access is a word.
- If MemWrite and MemRead are both set, the write wins and RData is 0.
- Word index is Addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Byte lanes are little-endian:
  - Byte k (k = Addr[1:0]) occupies bits [8k+7:8k].
  - Half h (h = Addr[1]) occupies bits [16h+15:16h].
- Alignment rules: a halfword needs Addr[0]=0; a word needs Addr[1:0]=0.
- Stores:
  - Only the selected lanes are written.
  - A byte store writes WData[7:0]; a halfword store writes WData[15:0].
  - Lanes that are not selected keep their old value.
- Loads:
  - The selected lane is right-justified into RData.
  - Extension uses the lane MSB, or zeros when UnsignedExt_Mem=1.
- The FSM has three states: IDLE, BUSY and DONE.
  - In IDLE with a request: latch Addr, WData and the controls, load the counter with WAIT_CYCLES-1, and go to BUSY. A misaligned request goes straight to DONE with the error flag set and performs no RAM access.
  - In BUSY: decrement the counter. When the counter is 0, perform the RAM read or write using the latched values and go to DONE.
  - In DONE: Done=1 (and AddrErr=1 if misaligned); RData is updated, or set to 0 on an error. DONE always returns to IDLE. DONE never accepts a new request, because the inputs in that cycle still show the finished instruction.
- Stall = (state==IDLE & request) | state==BUSY. Stall is forced to 0 while CLR=1.
- A valid instruction that is not a memory access passes through with no stall; Done stays 0.

## Timing
- Reset values: state IDLE, RData=0, Done=0, AddrErr=0, counter=0, Stall=0. RAM contents are not cleared.
- For a request first visible in cycle T:
  - Stall is high in cycles T through T+WAIT_CYCLES.
  - Done is high in cycle T+WAIT_CYCLES+1, where Stall is low and EX/MEM advances.
- A misaligned request gives Stall high in T only, and Done=AddrErr=1 in T+1.
- Back-to-back accesses: the next request is sampled in IDLE at T+WAIT_CYCLES+2, so the throughput is one access per WAIT_CYCLES+2 cycles.
- CLR asserted during BUSY:
  - The access is aborted and no RAM write occurs, because writes happen only on the BUSY-to-DONE edge.
  - State returns to IDLE with outputs at their reset values on the next edge.
- Inputs may change during BUSY without effect, since all operands are latched.

## Test plan
- Word store then load (WAIT_CYCLES=2): SW 0xDEADBEEF to 0x10, then LW 0x10 -> Stall high 3 cycles per access, Done pulses, RData=0xDEADBEEF.
- Byte extension:
  - SB 0x80 to 0x21, then LB 0x21 -> RData=0xFFFFFF80.
  - LBU 0x21 -> RData=0x00000080.
  - Word 0x20 keeps its other three bytes.
- Halfword lane: after SW 0x11223344 to 0x40, SH 0xABCD to 0x42 -> LW 0x40 returns 0xABCD3344; LH 0x42 returns 0xFFFFABCD.
- Misaligned: LW at 0x13 -> Stall one cycle, then Done=AddrErr=1 and RData=0; no RAM change.
- Reset mid-access: SW 0x55 to 0x8, with CLR in the first BUSY cycle -> word 0x8 unchanged, Done never pulses, Stall=0 after CLR.
- Non-memory and priority cases:
  - Valid_in=1 with no read or write -> Stall=0, Done=0.
  - MemWrite=MemRead=1 -> write performed, RData=0.
  - Byte=Half=1 at 0x5 -> byte access, no alignment error.
